// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, memory FSM encoding and class decoders
// shared by the LC3 pipeline controller.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   typedef enum logic [1:0] {
      MEM_READ  = 2'd0,
      MEM_IND   = 2'd1,
      MEM_WRITE = 2'd2,
      MEM_IDLE  = 2'd3
   } mem_state_t;

   function automatic logic is_alu(input logic [15:0] ir);
      return ir[15:12] inside {OP_ADD, OP_AND, OP_NOT};
   endfunction

   function automatic logic is_load(input logic [15:0] ir);
      return ir[15:12] inside {OP_LD, OP_LDR, OP_LDI};
   endfunction

   function automatic logic is_store(input logic [15:0] ir);
      return ir[15:12] inside {OP_ST, OP_STR, OP_STI};
   endfunction

   function automatic logic is_ctrl(input logic [15:0] ir);
      return ir[15:12] inside {OP_BR, OP_JMP};
   endfunction

   // IR[8:6] is a register source for these instructions
   function automatic logic uses_src1(input logic [15:0] ir);
      return is_alu(ir) | (ir[15:12] inside {OP_LDR, OP_STR, OP_JMP});
   endfunction

   // IR[2:0] is a register source only for register-mode ADD/AND
   function automatic logic uses_src2(input logic [15:0] ir);
      return (ir[15:12] inside {OP_ADD, OP_AND}) & ~ir[5];
   endfunction

endpackage

// File: rtl/lc3_controller_if.sv
// lc3_controller_if: control bundle between the pipeline
// sequencer (master) and the datapath (slave).
interface lc3_controller_if;

   logic        complete_data;
   logic [15:0] Instr_dout;
   logic [15:0] IR;
   logic [15:0] IR_Exec;
   logic [2:0]  NZP;
   logic [2:0]  psr;
   logic        enable_updatePC;
   logic        enable_fetch;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic        br_taken;
   logic        bypass_alu_1;
   logic        bypass_alu_2;
   logic        bypass_mem_1;
   logic        bypass_mem_2;
   logic [1:0]  mem_state;

   modport master (
      input  complete_data, Instr_dout, IR, IR_Exec, NZP, psr,
      output enable_updatePC, enable_fetch, enable_decode,
      output enable_execute, enable_writeback, br_taken,
      output bypass_alu_1, bypass_alu_2,
      output bypass_mem_1, bypass_mem_2, mem_state
   );

   modport slave (
      output complete_data, Instr_dout, IR, IR_Exec, NZP, psr,
      input  enable_updatePC, enable_fetch, enable_decode,
      input  enable_execute, enable_writeback, br_taken,
      input  bypass_alu_1, bypass_alu_2,
      input  bypass_mem_1, bypass_mem_2, mem_state
   );

endinterface

// File: rtl/lc3_mem_fsm.sv
// lc3_mem_fsm: data-memory access sequencer; indirect ops
// take an extra pointer fetch before the final read/write.
module lc3_mem_fsm
   import lc3_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       exe_prev,
   input  logic       complete_data,
   input  logic [3:0] opcode,
   output mem_state_t mem_state,
   output logic       mem_stall
);

   assign mem_stall = (mem_state != MEM_IDLE);

   // access sequencing, launched by the instruction leaving Execute
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_state <= MEM_IDLE;
      end else begin
         unique case (mem_state)
            MEM_IDLE: begin
               if (exe_prev) begin
                  unique case (1'b1)
                     opcode inside {OP_LD, OP_LDR}:  mem_state <= MEM_READ;
                     opcode inside {OP_LDI, OP_STI}: mem_state <= MEM_IND;
                     opcode inside {OP_ST, OP_STR}:  mem_state <= MEM_WRITE;
                     default:                        mem_state <= MEM_IDLE;
                  endcase
               end
            end
            MEM_IND: begin
               if (complete_data) begin
                  if (opcode == OP_LDI)
                     mem_state <= MEM_READ;
                  else if (opcode == OP_STI)
                     mem_state <= MEM_WRITE;
                  else
                     mem_state <= MEM_IDLE;
               end
            end
            MEM_READ, MEM_WRITE: begin
               if (complete_data)
                  mem_state <= MEM_IDLE;
            end
            default: mem_state <= MEM_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lc3_controller.sv
// lc3_controller: stage enables, branch bubble, memory stall
// and operand-forwarding selects for the LC3 pipeline.
module lc3_controller
   import lc3_pkg::*;
#(
   parameter int BR_STALL = 2
) (
   input  logic              clock,
   input  logic              reset,
   lc3_controller_if.master  bus
);

   localparam int CW = (BR_STALL < 2) ? 1 : $clog2(BR_STALL + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(BR_STALL);

   logic          run;
   logic          v_dec;
   logic          v_exe;
   logic          v_wb;
   logic [CW-1:0] ctrl_cnt;
   mem_state_t    mem_state;
   logic          mem_stall;
   logic          active;
   logic          go;
   logic          cnt_zero;
   logic          cnt_one;
   logic          mem_fwd;
   logic          hit1;
   logic          hit2;
   logic [2:0]    dr;

   lc3_mem_fsm u_mem_fsm (
      .clock         (clock),
      .reset         (reset),
      .exe_prev      (v_wb),
      .complete_data (bus.complete_data),
      .opcode        (bus.IR_Exec[15:12]),
      .mem_state     (mem_state),
      .mem_stall     (mem_stall)
   );

   // run masks the first cycle after reset so the ramp starts at cycle 1
   assign active   = run & ~reset;
   assign go       = active & ~mem_stall;
   assign cnt_zero = (ctrl_cnt == '0);
   assign cnt_one  = (ctrl_cnt == CNT_ONE);

   assign bus.enable_fetch    = go & cnt_zero;
   assign bus.enable_updatePC = go & (cnt_zero | cnt_one);
   assign bus.enable_decode   = go & v_dec & ~cnt_one;
   assign bus.enable_execute  = go & v_exe & ~cnt_one;
   assign mem_fwd = active & (mem_state == MEM_READ) & bus.complete_data;
   assign bus.enable_writeback = mem_stall ? mem_fwd : (active & v_wb);
   assign bus.br_taken = active & cnt_one & (|(bus.NZP & bus.psr));
   assign bus.mem_state = mem_state;

   assign dr   = bus.IR_Exec[11:9];
   assign hit1 = (dr == bus.IR[8:6]) & uses_src1(bus.IR);
   assign hit2 = (dr == bus.IR[2:0]) & uses_src2(bus.IR);

   assign bus.bypass_alu_1 = active & is_alu(bus.IR_Exec) & hit1;
   assign bus.bypass_alu_2 = active & is_alu(bus.IR_Exec) & hit2;
   assign bus.bypass_mem_1 = mem_fwd & is_load(bus.IR_Exec) & hit1;
   assign bus.bypass_mem_2 = mem_fwd & is_load(bus.IR_Exec) & hit2;

   // startup ramp: each stage becomes valid one cycle after its feeder
   always_ff @(posedge clock) begin
      if (reset) begin
         run   <= 1'b0;
         v_dec <= 1'b0;
         v_exe <= 1'b0;
         v_wb  <= 1'b0;
      end else begin
         run   <= 1'b1;
         v_dec <= bus.enable_fetch;
         v_exe <= bus.enable_decode;
         v_wb  <= bus.enable_execute;
      end
   end

   // branch bubble counter, frozen while memory stalls the pipe
   always_ff @(posedge clock) begin
      if (reset)
         ctrl_cnt <= '0;
      else if (is_ctrl(bus.Instr_dout) & bus.enable_fetch)
         ctrl_cnt <= CNT_LOAD;
      else if (!cnt_zero && !mem_stall)
         ctrl_cnt <= ctrl_cnt - CNT_ONE;
   end

endmodule

// File: tb/tb_lc3_controller.sv
// tb_lc3_controller: directed stimulus pushes expected output
// vectors; a negedge monitor pops and compares them.
module tb_lc3_controller;

   localparam logic [11:0] UPD = 12'h800;
   localparam logic [11:0] FET = 12'h400;
   localparam logic [11:0] DEC = 12'h200;
   localparam logic [11:0] EXE = 12'h100;
   localparam logic [11:0] WB  = 12'h080;
   localparam logic [11:0] BR  = 12'h040;
   localparam logic [11:0] BA1 = 12'h020;
   localparam logic [11:0] BA2 = 12'h010;
   localparam logic [11:0] BM1 = 12'h008;
   localparam logic [11:0] BM2 = 12'h004;
   localparam logic [11:0] MEM = 12'h003;
   localparam logic [11:0] EN  = UPD | FET | DEC | EXE | WB;
   localparam logic [11:0] BA  = BA1 | BA2;
   localparam logic [11:0] BM  = BM1 | BM2;
   localparam logic [11:0] ALL = 12'hFFF;
   localparam logic [11:0] M3  = 12'd3;

   localparam logic [15:0] NOP  = 16'h1020;
   localparam logic [15:0] BRZ  = 16'h0400;
   localparam logic [15:0] LDI  = 16'hA200;
   localparam logic [15:0] STR  = 16'h7242;

   typedef struct {
      string       name;
      logic [11:0] mask;
      logic [11:0] exp;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   lc3_controller_if bus ();

   lc3_controller #(.BR_STALL(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string n, input logic [11:0] m,
                      input logic [11:0] e);
      sb.push_back('{n, m, e});
   endtask

   // monitor: compare every expectation queued for this cycle
   always @(negedge clock) begin
      logic [11:0] act;
      exp_t e;
      act = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
             bus.enable_execute, bus.enable_writeback, bus.br_taken,
             bus.bypass_alu_1, bus.bypass_alu_2,
             bus.bypass_mem_1, bus.bypass_mem_2, bus.mem_state};
      while (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         if ((act & e.mask) === (e.exp & e.mask))
            passed++;
         else
            $display("FAIL %s: got %h need %h (mask %h)",
                     e.name, act & e.mask, e.exp & e.mask, e.mask);
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      reset             = 1'b1;
      bus.Instr_dout    = NOP;
      bus.IR            = NOP;
      bus.IR_Exec       = NOP;
      bus.NZP           = 3'b000;
      bus.psr           = 3'b000;
      bus.complete_data = 1'b0;

      step(); step();
      chk("rst", ALL, M3);
      step(); reset = 1'b0;
      chk("rel0", ALL, M3);
      step(); chk("ramp1", EN | MEM | BA, UPD | FET | BA1 | M3);
      step(); chk("ramp2", EN | MEM, UPD | FET | DEC | M3);
      step(); chk("ramp3", EN | MEM, UPD | FET | DEC | EXE | M3);
      step(); chk("ramp4", EN | MEM, EN | M3);

      step(); bus.Instr_dout = BRZ;
      chk("br_t0", EN | BR, EN);
      step(); bus.Instr_dout = NOP;
      chk("br_t1", EN | BR, DEC | EXE | WB);
      step(); bus.NZP = 3'b010; bus.psr = 3'b010;
      chk("br_t2", EN | BR, UPD | WB | BR);
      step(); bus.NZP = 3'b000;
      chk("br_t3", EN | BR, UPD | FET);
      repeat (3) step();

      step(); bus.Instr_dout = BRZ; bus.psr = 3'b100;
      step(); bus.Instr_dout = NOP;
      step(); bus.NZP = 3'b010;
      chk("nt_t2", UPD | FET | BR, UPD);
      step(); bus.NZP = 3'b000; bus.psr = 3'b000;
      chk("nt_t3", FET | BR, FET);
      repeat (3) step();

      step(); bus.IR_Exec = LDI; bus.IR = 16'h1441;
      bus.complete_data = 1'b1;
      chk("ldi_c0", EN | MEM | BA | BM, EN | M3);
      step(); chk("ldi_ind", EN | MEM | BM, 12'd1);
      step(); chk("ldi_read", EN | MEM | BM, WB | BM1 | BM2);
      step(); chk("ldi_idle", EN | MEM | BM, UPD | FET | M3);
      step(); bus.IR_Exec = NOP; bus.IR = NOP;
      bus.complete_data = 1'b0;
      repeat (2) step();

      step(); bus.IR_Exec = STR;
      chk("str_s0", EN | MEM, EN | M3);
      step(); chk("str_w1", FET | WB | MEM, 12'd2);
      step(); chk("str_w2", FET | WB | MEM, 12'd2);
      step(); bus.complete_data = 1'b1;
      chk("str_w3", FET | WB | MEM, 12'd2);
      step(); bus.complete_data = 1'b0; bus.IR_Exec = NOP;
      chk("str_done", FET | WB | MEM, FET | M3);
      repeat (3) step();

      step(); bus.IR_Exec = 16'h1283; bus.IR = 16'h1841;
      chk("byp_rr", BA | BM, BA1 | BA2);
      step(); bus.IR = 16'h1861;
      chk("byp_imm", BA | BM, BA1);
      step(); bus.IR = 16'h1883;
      chk("byp_miss", BA, 12'd0);
      step(); bus.IR = 16'h7A40;
      chk("byp_str", BA, BA1);

      step(); bus.IR_Exec = LDI; bus.IR = NOP;
      chk("rma_0", WB | MEM, WB | M3);
      step(); chk("rma_ind", EN | MEM, 12'd1);
      step(); reset = 1'b1;
      chk("rma_rst", ALL, 12'd1);
      step(); reset = 1'b0; bus.IR_Exec = NOP;
      chk("rma_idle", ALL, M3);
      step(); chk("rma_ramp", FET | WB | MEM, FET | M3);

      step(); step();
      checks++;
      if (sb.size() == 0)
         passed++;
      else
         $display("FAIL drain: got %0d left need 0", sb.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
